// File: rtl/forward_quantizer.sv
// Scalar forward quantizer: maps one NxN block of transform coefficients (raster order) to signed levels.
// Two-stage pipeline (abs*scale | round, shift, clamp, sign) with per-block nonzero count and last position.
module forward_quantizer #(
  parameter int COEFF_WIDTH = 16,
  parameter int QP_WIDTH    = 6,
  parameter int MAX_SIZE    = 32,
  parameter int BIT_DEPTH   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [2:0]                      i_log2_size,
  input  logic [QP_WIDTH-1:0]             i_qp,
  input  logic                            i_intra,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [COEFF_WIDTH-1:0]          i_in_coeff,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [COEFF_WIDTH-1:0]          o_out_level,
  output logic                            o_out_last,
  output logic                            o_done,
  output logic [2*$clog2(MAX_SIZE):0]     o_nz_count,
  output logic [2*$clog2(MAX_SIZE)-1:0]   o_last_pos
);

  localparam int LOG2_MAX = $clog2(MAX_SIZE);
  localparam int CNT_W    = 2 * LOG2_MAX + 1;
  localparam int POS_W    = 2 * LOG2_MAX;
  localparam int MAG_W    = COEFF_WIDTH + 1;
  localparam int SCALE_W  = 15;
  localparam int PROD_W   = MAG_W + SCALE_W;
  localparam int ACC_W    = 48;
  localparam logic [COEFF_WIDTH-2:0] MAX_MAG = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [CNT_W-1:0]       r_total;
  logic [SCALE_W-1:0]     r_scale;
  logic [5:0]             r_qbits;
  logic [ACC_W-1:0]       r_offset;
  logic [CNT_W-1:0]       r_in_cnt;
  logic [CNT_W-1:0]       r_out_cnt;
  logic                   r_s1_vld;
  logic                   r_s1_sign;
  logic [PROD_W-1:0]      r_s1_prod;
  logic                   r_out_vld;
  logic [COEFF_WIDTH-1:0] r_out_level;
  logic [CNT_W-1:0]       r_nz_count;
  logic [POS_W-1:0]       r_last_pos;

  logic [2:0]             w_log2;
  logic [3:0]             w_qp_div;
  logic [2:0]             w_qp_mod;
  logic [SCALE_W-1:0]     w_scale;
  logic [5:0]             w_qbits;
  logic [ACC_W-1:0]       w_round_base;
  logic [ACC_W-1:0]       w_offset;
  logic [CNT_W-1:0]       w_total;
  logic                   w_start_go;
  logic                   w_advance;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_last_in;
  logic                   w_last_idx;
  logic [MAG_W-1:0]       w_coeff_ext;
  logic [MAG_W-1:0]       w_mag_in;
  logic [PROD_W-1:0]      w_prod;
  logic [ACC_W-1:0]       w_sum;
  logic [ACC_W-1:0]       w_quot;
  logic [COEFF_WIDTH-2:0] w_mag_out;
  logic [COEFF_WIDTH-1:0] w_level;

  // Block configuration decode, only latched when a block starts
  always_comb begin
    w_log2 = i_log2_size;
    if (i_log2_size < 3'd2) begin
      w_log2 = 3'd2;
    end else if (i_log2_size > 3'(LOG2_MAX)) begin
      w_log2 = 3'(LOG2_MAX);
    end
  end

  assign w_qp_div = 4'(i_qp / 6);
  assign w_qp_mod = 3'(i_qp % 6);

  always_comb begin
    w_scale = 15'd26214;
    case (w_qp_mod)
      3'd0:    w_scale = 15'd26214;
      3'd1:    w_scale = 15'd23302;
      3'd2:    w_scale = 15'd20560;
      3'd3:    w_scale = 15'd18396;
      3'd4:    w_scale = 15'd16384;
      3'd5:    w_scale = 15'd14564;
      default: w_scale = 15'd26214;
    endcase
  end

  assign w_qbits      = 6'(29 - BIT_DEPTH) + 6'(w_qp_div) - 6'(w_log2);
  assign w_round_base = i_intra ? ACC_W'(171) : ACC_W'(85);
  assign w_offset     = w_round_base << (w_qbits - 6'd9);
  assign w_total      = CNT_W'(1) << {w_log2, 1'b0};
  assign w_start_go   = (r_state == S_IDLE) && i_start;

  // Handshake: both stages hold whenever a level is waiting and not taken
  assign w_advance  = !r_out_vld || i_out_ready;
  assign w_in_fire  = i_in_valid && o_in_ready;
  assign w_out_fire = r_out_vld && i_out_ready;
  assign w_last_in  = (r_in_cnt == r_total - CNT_W'(1));
  assign w_last_idx = (r_out_cnt == r_total - CNT_W'(1));

  // Stage 1 combinational: magnitude and scale product
  assign w_coeff_ext = {i_in_coeff[COEFF_WIDTH-1], i_in_coeff};
  assign w_mag_in    = i_in_coeff[COEFF_WIDTH-1] ? (~w_coeff_ext + MAG_W'(1)) : w_coeff_ext;
  assign w_prod      = PROD_W'(w_mag_in) * PROD_W'(r_scale);

  // Stage 2 combinational: rounding offset, shift, clamp, sign restore
  assign w_sum     = ACC_W'(r_s1_prod) + r_offset;
  assign w_quot    = w_sum >> r_qbits;
  assign w_mag_out = (w_quot > ACC_W'(MAX_MAG)) ? MAX_MAG : w_quot[COEFF_WIDTH-2:0];
  assign w_level   = r_s1_sign ? -{1'b0, w_mag_out} : {1'b0, w_mag_out};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_vld    <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_prod   <= '0;
      r_out_vld   <= 1'b0;
      r_out_level <= '0;
    end else if (w_advance) begin
      r_s1_vld  <= w_in_fire;
      if (w_in_fire) begin
        r_s1_sign <= i_in_coeff[COEFF_WIDTH-1];
        r_s1_prod <= w_prod;
      end
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_level <= w_level;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_total    <= CNT_W'(16);
      r_scale    <= '0;
      r_qbits    <= '0;
      r_offset   <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_nz_count <= '0;
      r_last_pos <= '0;
    end else if (w_start_go) begin
      r_total    <= w_total;
      r_scale    <= w_scale;
      r_qbits    <= w_qbits;
      r_offset   <= w_offset;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_nz_count <= '0;
      r_last_pos <= '0;
    end else begin
      if (w_in_fire) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      end
      // Statistics follow levels as they are handed to the consumer
      if (w_out_fire) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
        if (r_out_level != '0) begin
          r_nz_count <= r_nz_count + CNT_W'(1);
          r_last_pos <= r_out_cnt[POS_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_in_fire && w_last_in) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_fire && w_last_idx) w_state_nxt = S_DONE;
      S_DONE:  if (!i_start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == S_RUN) && w_advance && (r_in_cnt < r_total);
    o_done     = (r_state == S_DONE);
    o_out_last = r_out_vld && w_last_idx;
  end

  assign o_out_valid = r_out_vld;
  assign o_out_level = r_out_level;
  assign o_nz_count  = r_nz_count;
  assign o_last_pos  = r_last_pos;

endmodule

// File: tb/tb_forward_quantizer.sv
// Directed bench for forward_quantizer: hand-derived levels, stall robustness, reset mid-block.
module tb_forward_quantizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  log2_size = 3'd2;
  logic [5:0]  qp = 6'd0;
  logic        intra = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_coeff = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_level;
  logic        out_last;
  logic        done;
  logic [10:0] nz_count;
  logic [9:0]  last_pos;

  int n_total = 0;
  int n_bad = 0;
  int ncyc = 0;
  int stim [1024];
  int expv [1024];

  forward_quantizer dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_log2_size (log2_size),
    .i_qp        (qp),
    .i_intra     (intra),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_coeff  (in_coeff),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_level (out_level),
    .o_out_last  (out_last),
    .o_done      (done),
    .o_nz_count  (nz_count),
    .o_last_pos  (last_pos)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ncyc++;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_vectors();
    for (int i = 0; i < 1024; i++) begin
      stim[i] = 0;
      expv[i] = 0;
    end
  endtask

  // n is the block size the DUT should use after clamping the raw log2 field
  task automatic run_block(input int raw_l2, input int n, input int q, input bit intr,
                           input bit stall, input bit chk_lat, input int exp_nz, input int exp_last);
    int acc_cyc = -1;
    int out_cyc = -1;
    @(negedge clk);
    log2_size = 3'(raw_l2);
    qp        = 6'(q);
    intra     = intr;
    start     = 1'b1;
    fork
      begin
        int i = 0;
        int guard = 0;
        while (i < n && guard < 5000) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_coeff = 16'(stim[i]);
          #1;
          if (in_ready) begin
            if (acc_cyc < 0) acc_cyc = ncyc;
            i++;
          end
          guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (i < n) chk("in_timeout", i, n);
      end
      begin
        int k = 0;
        int guard = 0;
        while (k < n && guard < 5000) begin
          @(negedge clk);
          out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          #1;
          if (out_valid && out_ready) begin
            if (out_cyc < 0) out_cyc = ncyc;
            chk($sformatf("lvl[%0d]", k), int'($signed(out_level)), expv[k]);
            chk($sformatf("last[%0d]", k), int'(out_last), int'(k == n - 1));
            k++;
          end
          guard++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        if (k < n) chk("out_timeout", k, n);
      end
    join
    if (chk_lat) chk("latency", out_cyc - acc_cyc, 2);
    for (int w = 0; w < 20 && !done; w++) @(negedge clk);
    chk("done_rise", int'(done), 1);
    chk("nz_count", int'(nz_count), exp_nz);
    chk("last_pos", int'(last_pos), exp_last);
    chk("in_ready_done", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk("done_held", int'(done), 1);
    chk("nz_stable", int'(nz_count), exp_nz);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("done_fall", int'(done), 0);
  endtask

  initial begin
    int nz;
    int lp;
    int m;

    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_level", int'(out_level), 0);
    chk("rst_nz", int'(nz_count), 0);
    chk("rst_last_pos", int'(last_pos), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // QP=4 4x4 intra: qbits 19, scale 16384, offset 175104
    // 1000 -> (16384000+175104)>>19 = 31 ; 100 -> 1813504>>19 = 3
    clear_vectors();
    stim[0] = 1000;  expv[0] = 31;
    stim[1] = -1000; expv[1] = -31;
    stim[2] = 100;   expv[2] = 3;
    run_block(2, 16, 4, 1'b1, 1'b0, 1'b1, 3, 2);

    // QP=22 with log2 field 0 (clamped to 4x4): qbits 22, 10000 -> 165240832>>22 = 39
    clear_vectors();
    stim[15] = 10000; expv[15] = 39;
    run_block(0, 16, 22, 1'b1, 1'b0, 1'b0, 1, 15);

    // QP=0 with log2 field 7 (clamped to 32x32) inter: qbits 16, 32768*26214+10880 >> 16 = 13107
    clear_vectors();
    for (int i = 0; i < 1024; i++) begin
      stim[i] = -32768;
      expv[i] = -13107;
    end
    run_block(7, 1024, 0, 1'b0, 1'b0, 1'b0, 1024, 1023);

    // QP=10 8x8 intra: qbits 19, scale 16384 -> level = (|c|*16384+175104)>>19 = (|c|+10)>>5
    clear_vectors();
    nz = 0;
    lp = 0;
    for (int i = 0; i < 64; i++) begin
      stim[i] = i * 97 - 3000;
      m = (stim[i] < 0) ? -stim[i] : stim[i];
      expv[i] = (stim[i] < 0) ? -((m + 10) >> 5) : ((m + 10) >> 5);
      if (expv[i] != 0) begin
        nz++;
        lp = i;
      end
    end
    run_block(3, 64, 10, 1'b1, 1'b0, 1'b1, nz, lp);
    run_block(3, 64, 10, 1'b1, 1'b1, 1'b0, nz, lp);

    // All-zero 16x16 block
    clear_vectors();
    run_block(4, 256, 30, 1'b0, 1'b0, 1'b0, 0, 0);

    // Reset after 5 accepted inputs of a 4x4 block
    clear_vectors();
    @(negedge clk);
    log2_size = 3'd2;
    qp        = 6'd4;
    intra     = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    begin
      int acc = 0;
      int guard = 0;
      while (acc < 5 && guard < 50) begin
        in_valid = 1'b1;
        in_coeff = 16'd1000;
        #1;
        if (in_ready) acc++;
        @(negedge clk);
        guard++;
      end
      chk("rst_mid_accepts", acc, 5);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_level", int'(out_level), 0);
    chk("mid_rst_nz", int'(nz_count), 0);
    chk("mid_rst_last_pos", int'(last_pos), 0);
    @(negedge clk);
    rst = 1'b0;

    clear_vectors();
    stim[0] = 1000;  expv[0] = 31;
    stim[1] = -1000; expv[1] = -31;
    stim[2] = 100;   expv[2] = 3;
    run_block(2, 16, 4, 1'b1, 1'b0, 1'b1, 3, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
